// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: single-port data RAM with registered read, write-first collisions, range check and post-reset clear sweep
module data_memory_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH = 256,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] writedata,
  input  logic              memread,
  input  logic              memwrite,
  output logic [DATA_W-1:0] readdata,
  output logic              readvalid,
  output logic              ready,
  output logic              addrerr
);
  localparam int PTR_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state, state_n;
  logic [PTR_W-1:0] ptr, ptr_n, idx, wa;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] wd;
  logic we, run, in_range;
  assign idx = address[PTR_W-1:0];
  assign in_range = {1'b0, address} < LIMIT;
  assign run = state == RUN;
  assign ready = run;
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    we = 1'b0;
    wa = ptr;
    wd = INIT_VALUE;
    if (!run) begin
      state_n = (!CLEAR_ON_RESET || ptr == LAST) ? RUN : CLEAR;
      ptr_n = ptr == LAST ? ptr : ptr + 1'b1;
      we = RESET && CLEAR_ON_RESET;
    end else if (memwrite && in_range) begin
      we = RESET;
      wa = idx;
      wd = writedata;
    end
  end
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state <= CLEAR;
      ptr <= '0;
      readdata <= '0;
      readvalid <= 1'b0;
      addrerr <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      readvalid <= run && memread;
      addrerr <= run && (memread || memwrite) && !in_range;
      if (run && memread) readdata <= !in_range ? '0 : memwrite ? writedata : mem[idx];
    end
  end
  // the write port is shared by the clear sweep and normal writes; reset cycles never write
  always_ff @(posedge CLK) if (we) mem[wa] <= wd;
endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb_data_memory_ctrl: two configurations (256 words init 0x00, 200 words init 0xA5) driven in lockstep and checked against a reference model
module tb_data_memory_ctrl;
  logic clk = 1'b0;
  logic rst_n, mr, mw;
  logic [7:0] addr, wd;
  logic [1:0][7:0] dut_rd;
  logic [1:0] dut_rv, dut_rdy, dut_ae;
  int checks = 0;
  int errors = 0;
  int cnt [2];
  logic m_rdy [2];
  logic m_rv [2];
  logic m_ae [2];
  logic [7:0] m_rd [2];
  logic [7:0] m_mem [2][256];
  typedef struct {
    logic mr, mw;
    logic [7:0] a, wd;
    logic [7:0] rd0;
    logic rv0, ae0;
    logic [7:0] rd1;
    logic rv1, ae1;
  } vec_t;
  vec_t tv [20];
  always #25 clk = ~clk;
  data_memory_ctrl d0 (
    .CLK(clk), .RESET(rst_n), .address(addr), .writedata(wd), .memread(mr), .memwrite(mw),
    .readdata(dut_rd[0]), .readvalid(dut_rv[0]), .ready(dut_rdy[0]), .addrerr(dut_ae[0])
  );
  data_memory_ctrl #(.DEPTH(200), .INIT_VALUE(8'hA5)) d1 (
    .CLK(clk), .RESET(rst_n), .address(addr), .writedata(wd), .memread(mr), .memwrite(mw),
    .readdata(dut_rd[1]), .readvalid(dut_rv[1]), .ready(dut_rdy[1]), .addrerr(dut_ae[1])
  );
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  // behavioural view: the whole array becomes INIT once DEPTH clean edges have passed since reset
  task automatic model_edge(input int k);
    int dep;
    int a;
    logic [7:0] ini;
    dep = k ? 200 : 256;
    ini = k ? 8'hA5 : 8'h00;
    a = int'(addr);
    if (!rst_n) begin
      m_rdy[k] = 1'b0;
      cnt[k] = 0;
      m_rd[k] = 8'h00;
      m_rv[k] = 1'b0;
      m_ae[k] = 1'b0;
    end else if (!m_rdy[k]) begin
      cnt[k]++;
      m_rv[k] = 1'b0;
      m_ae[k] = 1'b0;
      if (cnt[k] == dep) begin
        m_rdy[k] = 1'b1;
        for (int j = 0; j < 256; j++) m_mem[k][j] = ini;
      end
    end else begin
      if (mw && a < dep) m_mem[k][a] = wd;
      m_ae[k] = (mr || mw) && a >= dep;
      m_rv[k] = mr;
      if (mr) m_rd[k] = a < dep ? m_mem[k][a] : 8'h00;
    end
  endtask
  task automatic tick();
    for (int k = 0; k < 2; k++) model_edge(k);
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("m%0d readdata", k), dut_rd[k], m_rd[k]);
      chk($sformatf("m%0d readvalid", k), 8'(dut_rv[k]), 8'(m_rv[k]));
      chk($sformatf("m%0d ready", k), 8'(dut_rdy[k]), 8'(m_rdy[k]));
      chk($sformatf("m%0d addrerr", k), 8'(dut_ae[k]), 8'(m_ae[k]));
    end
  endtask
  task automatic idle();
    mr = 1'b0;
    mw = 1'b0;
    addr = 8'h00;
    wd = 8'h00;
  endtask
  task automatic rnd();
    {mr, mw} = 2'($urandom_range(0, 3));
    addr = 8'($urandom_range(0, 255));
    wd = 8'($urandom_range(0, 255));
  endtask
  initial begin
    tv = '{
      '{1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0},
      '{1'b1, 1'b0, 8'h7F, 8'h00, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0},
      '{1'b1, 1'b0, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1},
      '{1'b1, 1'b0, 8'h3C, 8'h00, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0},
      '{1'b0, 1'b1, 8'h10, 8'h5A, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0},
      '{1'b1, 1'b0, 8'h10, 8'h00, 8'h5A, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b0},
      '{1'b1, 1'b1, 8'h20, 8'hC3, 8'hC3, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b0},
      '{1'b1, 1'b0, 8'h20, 8'h00, 8'hC3, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b0},
      '{1'b0, 1'b1, 8'hC8, 8'h77, 8'hC3, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1},
      '{1'b1, 1'b0, 8'hC8, 8'h00, 8'h77, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1},
      '{1'b1, 1'b0, 8'hC7, 8'h00, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0},
      '{1'b0, 1'b1, 8'h01, 8'h11, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0},
      '{1'b0, 1'b1, 8'h02, 8'h22, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0},
      '{1'b0, 1'b1, 8'h03, 8'h33, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0},
      '{1'b0, 1'b1, 8'h04, 8'h44, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0},
      '{1'b1, 1'b0, 8'h01, 8'h00, 8'h11, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0},
      '{1'b1, 1'b0, 8'h02, 8'h00, 8'h22, 1'b1, 1'b0, 8'h22, 1'b1, 1'b0},
      '{1'b1, 1'b0, 8'h03, 8'h00, 8'h33, 1'b1, 1'b0, 8'h33, 1'b1, 1'b0},
      '{1'b1, 1'b0, 8'h04, 8'h00, 8'h44, 1'b1, 1'b0, 8'h44, 1'b1, 1'b0},
      '{1'b0, 1'b0, 8'h00, 8'h00, 8'h44, 1'b0, 1'b0, 8'h44, 1'b0, 1'b0}
    };
    rst_n = 1'b0;
    idle();
    tick();
    tick();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset readdata m%0d", k), dut_rd[k], 8'h00);
      chk($sformatf("reset ready m%0d", k), 8'(dut_rdy[k]), 8'h00);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      if (i <= 190) rnd(); else idle();
      tick();
      if (i == 199 || i == 200) chk($sformatf("sweep200 ready edge %0d", i), 8'(dut_rdy[1]), 8'(i >= 200));
      if (i == 255 || i == 256) chk($sformatf("sweep256 ready edge %0d", i), 8'(dut_rdy[0]), 8'(i >= 256));
    end
    for (int i = 0; i < 20; i++) begin
      mr = tv[i].mr;
      mw = tv[i].mw;
      addr = tv[i].a;
      wd = tv[i].wd;
      tick();
      chk($sformatf("vec%0d rd0", i), dut_rd[0], tv[i].rd0);
      chk($sformatf("vec%0d rv0", i), 8'(dut_rv[0]), 8'(tv[i].rv0));
      chk($sformatf("vec%0d ae0", i), 8'(dut_ae[0]), 8'(tv[i].ae0));
      chk($sformatf("vec%0d rd1", i), dut_rd[1], tv[i].rd1);
      chk($sformatf("vec%0d rv1", i), 8'(dut_rv[1]), 8'(tv[i].rv1));
      chk($sformatf("vec%0d ae1", i), 8'(dut_ae[1]), 8'(tv[i].ae1));
    end
    for (int i = 0; i < 300; i++) begin
      rnd();
      tick();
    end
    mr = 1'b0;
    mw = 1'b1;
    addr = 8'h05;
    wd = 8'h99;
    tick();
    mr = 1'b1;
    mw = 1'b0;
    tick();
    chk("pre-reset read 05 m0", dut_rd[0], 8'h99);
    chk("pre-reset read 05 m1", dut_rd[1], 8'h99);
    rst_n = 1'b0;
    tick();
    chk("run reset readdata m0", dut_rd[0], 8'h00);
    chk("run reset ready m0", 8'(dut_rdy[0]), 8'h00);
    chk("run reset readvalid m0", 8'(dut_rv[0]), 8'h00);
    rst_n = 1'b1;
    idle();
    for (int i = 0; i < 100; i++) tick();
    rst_n = 1'b0;
    rnd();
    tick();
    chk("sweep reset ready m1", 8'(dut_rdy[1]), 8'h00);
    rst_n = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      if (i <= 150) rnd(); else idle();
      tick();
      if (i == 255 || i == 256) chk($sformatf("resweep ready edge %0d", i), 8'(dut_rdy[0]), 8'(i >= 256));
    end
    mr = 1'b1;
    addr = 8'h05;
    tick();
    chk("post-reset read 05 m0", dut_rd[0], 8'h00);
    chk("post-reset read 05 m1", dut_rd[1], 8'hA5);
    idle();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
